bp_pht_sched: RTL and testbench

Scheduler and history controller in front of the single-ported agree-predictor pattern history table (PHT).

- Arbitrates the one PHT port between fetch-stage lookups and execute-stage resolved-branch updates.
- Buffers resolved updates in a small FIFO so that no resolution is lost.
- Maintains the speculative and committed global history registers (GHR) that feed the gshare index.
- Restores speculative history when a branch mispredicts.

---
 rtl/bp_pht_sched.sv | 123 ++++++++++++
 tb/tb_bp_pht_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_pht_sched.sv
// PHT port scheduler: arbitrates fetch lookups against queued branch updates
// and keeps the speculative and committed global history registers.
module bp_pht_sched #(
    parameter int DEPTH      = 4,
    parameter int GHR_W      = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_lkp_req,
    input  logic [31:0]      i_lkp_pc,
    output logic             o_lkp_gnt,
    output logic [GHR_W-1:0] o_lkp_ghr,
    input  logic             i_spec_valid,
    input  logic             i_spec_taken,
    input  logic             i_res_valid,
    output logic             o_res_ready,
    input  logic [31:0]      i_res_pc,
    input  logic [GHR_W-1:0] i_res_ghr,
    input  logic             i_res_taken,
    input  logic             i_res_bias,
    input  logic             i_res_mispredict,
    output logic [31:0]      o_pht_pc,
    output logic [GHR_W-1:0] o_pht_ghr,
    output logic             o_pht_valid_update,
    output logic             o_pht_actual_taken,
    output logic             o_pht_bias,
    output logic [GHR_W-1:0] o_commit_ghr
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [SW-1:0] SMAX     = STARVE_MAX[SW-1:0];

    logic [31:0]      q_pc    [DEPTH];
    logic [GHR_W-1:0] q_ghr   [DEPTH];
    logic             q_taken [DEPTH];
    logic             q_bias  [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [SW-1:0]    starve;
    logic [GHR_W-1:0] spec_ghr;
    logic [GHR_W-1:0] commit_ghr;

    logic full;
    logic empty;
    logic force_upd;
    logic upd_issue;
    logic push;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign force_upd = full || (starve == SMAX);
    assign upd_issue = !empty && (force_upd || !i_lkp_req);
    assign push      = i_res_valid && !full;

    assign o_res_ready  = !full;
    assign o_lkp_gnt    = i_lkp_req && !upd_issue;
    assign o_lkp_ghr    = spec_ghr;
    assign o_commit_ghr = commit_ghr;

    // Idle port presents the lookup fields so the PHT read path stays warm.
    assign o_pht_valid_update = upd_issue;
    assign o_pht_pc           = upd_issue ? q_pc[rd_ptr]    : i_lkp_pc;
    assign o_pht_ghr          = upd_issue ? q_ghr[rd_ptr]   : spec_ghr;
    assign o_pht_actual_taken = upd_issue ? q_taken[rd_ptr] : 1'b0;
    assign o_pht_bias         = upd_issue ? q_bias[rd_ptr]  : 1'b0;

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= i_res_pc;
            q_ghr[wr_ptr]   <= i_res_ghr;
            q_taken[wr_ptr] <= i_res_taken;
            q_bias[wr_ptr]  <= i_res_bias;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (upd_issue)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !upd_issue)
                count <= count + 1'b1;
            else if (!push && upd_issue)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            starve <= '0;
        else if (upd_issue || empty)
            starve <= '0;
        else if (starve != SMAX)
            starve <= starve + 1'b1;
    end

    // A mispredict rebuilds history from the resolved snapshot and wins
    // over any prediction made in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            spec_ghr   <= '0;
            commit_ghr <= '0;
        end else begin
            if (push && i_res_mispredict)
                spec_ghr <= {i_res_ghr[GHR_W-2:0], i_res_taken};
            else if (i_spec_valid && o_lkp_gnt)
                spec_ghr <= {spec_ghr[GHR_W-2:0], i_spec_taken};
            if (push)
                commit_ghr <= {commit_ghr[GHR_W-2:0], i_res_taken};
        end
    end

endmodule

// File: tb/tb_bp_pht_sched.sv
// Self-checking bench for bp_pht_sched: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_bp_pht_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lkp_req;
    logic [31:0] lkp_pc;
    logic        lkp_gnt;
    logic [7:0]  lkp_ghr;
    logic        spec_valid;
    logic        spec_taken;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic [7:0]  res_ghr;
    logic        res_taken;
    logic        res_bias;
    logic        res_mis;
    logic [31:0] pht_pc;
    logic [7:0]  pht_ghr;
    logic        pht_vu;
    logic        pht_taken;
    logic        pht_bias;
    logic [7:0]  commit_ghr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bp_pht_sched #(.DEPTH(4), .GHR_W(8), .STARVE_MAX(3)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_lkp_req          (lkp_req),
        .i_lkp_pc           (lkp_pc),
        .o_lkp_gnt          (lkp_gnt),
        .o_lkp_ghr          (lkp_ghr),
        .i_spec_valid       (spec_valid),
        .i_spec_taken       (spec_taken),
        .i_res_valid        (res_valid),
        .o_res_ready        (res_ready),
        .i_res_pc           (res_pc),
        .i_res_ghr          (res_ghr),
        .i_res_taken        (res_taken),
        .i_res_bias         (res_bias),
        .i_res_mispredict   (res_mis),
        .o_pht_pc           (pht_pc),
        .o_pht_ghr          (pht_ghr),
        .o_pht_valid_update (pht_vu),
        .o_pht_actual_taken (pht_taken),
        .o_pht_bias         (pht_bias),
        .o_commit_ghr       (commit_ghr)
    );

    typedef struct {
        logic        lkp;
        logic        rv;
        logic [31:0] pc;
        logic        gnt;
        logic        rdy;
        logic        vu;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  ghr;
        logic        taken;
        logic        bias;
    } ent_t;

    vec_t tbl[18];

    ent_t m_q[$];
    int   m_starve;
    logic [7:0] m_spec;
    logic [7:0] m_commit;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        lkp_req = 0; lkp_pc = 32'hF000;
        spec_valid = 0; spec_taken = 0;
        res_valid = 0; res_pc = 0; res_ghr = 0;
        res_taken = 0; res_bias = 0; res_mis = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        m_spec = 0;
        m_commit = 0;
    endtask

    // Compare the current cycle's outputs, then advance the model by one edge.
    task automatic model_cycle();
        bit   full, upd, gnt, push;
        ent_t e;
        full = (m_q.size() == 4);
        upd  = (m_q.size() > 0) && (full || m_starve == 3 || !lkp_req);
        gnt  = lkp_req && !upd;
        push = res_valid && !full;
        chk("rnd_gnt", {31'd0, lkp_gnt}, {31'd0, gnt});
        chk("rnd_ready", {31'd0, res_ready}, {31'd0, !full});
        chk("rnd_vu", {31'd0, pht_vu}, {31'd0, upd});
        chk("rnd_lkp_ghr", {24'd0, lkp_ghr}, {24'd0, m_spec});
        chk("rnd_commit", {24'd0, commit_ghr}, {24'd0, m_commit});
        if (upd) begin
            e = m_q[0];
            chk("rnd_pht_pc", pht_pc, e.pc);
            chk("rnd_pht_ghr", {24'd0, pht_ghr}, {24'd0, e.ghr});
            chk("rnd_pht_tk", {31'd0, pht_taken}, {31'd0, e.taken});
            chk("rnd_pht_bias", {31'd0, pht_bias}, {31'd0, e.bias});
        end else begin
            chk("rnd_pht_pc", pht_pc, lkp_pc);
            chk("rnd_pht_ghr", {24'd0, pht_ghr}, {24'd0, m_spec});
        end
        if (upd || m_q.size() == 0) m_starve = 0;
        else if (m_starve < 3) m_starve++;
        if (upd) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back('{res_pc, res_ghr, res_taken, res_bias});
            m_commit = {m_commit[6:0], res_taken};
        end
        if (push && res_mis) m_spec = {res_ghr[6:0], res_taken};
        else if (spec_valid && gnt) m_spec = {m_spec[6:0], spec_taken};
    endtask

    initial begin
        tbl[0]  = '{1, 1, 32'h100, 1, 1, 0, 32'hF000};
        tbl[1]  = '{1, 0, 32'h0,   1, 1, 0, 32'hF000};
        tbl[2]  = '{1, 0, 32'h0,   1, 1, 0, 32'hF000};
        tbl[3]  = '{1, 0, 32'h0,   1, 1, 0, 32'hF000};
        tbl[4]  = '{1, 0, 32'h0,   0, 1, 1, 32'h100};
        tbl[5]  = '{1, 0, 32'h0,   1, 1, 0, 32'hF000};
        tbl[6]  = '{1, 1, 32'h200, 1, 1, 0, 32'hF000};
        tbl[7]  = '{1, 1, 32'h201, 1, 1, 0, 32'hF000};
        tbl[8]  = '{1, 1, 32'h202, 1, 1, 0, 32'hF000};
        tbl[9]  = '{1, 1, 32'h203, 1, 1, 0, 32'hF000};
        tbl[10] = '{1, 0, 32'h0,   0, 0, 1, 32'h200};
        tbl[11] = '{1, 0, 32'h0,   1, 1, 0, 32'hF000};
        tbl[12] = '{1, 0, 32'h0,   1, 1, 0, 32'hF000};
        tbl[13] = '{1, 0, 32'h0,   1, 1, 0, 32'hF000};
        tbl[14] = '{1, 0, 32'h0,   0, 1, 1, 32'h201};
        tbl[15] = '{0, 0, 32'h0,   0, 1, 1, 32'h202};
        tbl[16] = '{0, 0, 32'h0,   0, 1, 1, 32'h203};
        tbl[17] = '{0, 0, 32'h0,   0, 1, 0, 32'hF000};

        rst_n = 0;
        clear_inputs();
        #1;
        chk("rst_ready", {31'd0, res_ready}, 32'd1);
        chk("rst_vu", {31'd0, pht_vu}, 32'd0);
        chk("rst_spec", {24'd0, lkp_ghr}, 32'd0);
        chk("rst_commit", {24'd0, commit_ghr}, 32'd0);
        do_reset();

        // Starvation and FIFO-full sequences
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            clear_inputs();
            lkp_req = tbl[i].lkp;
            res_valid = tbl[i].rv;
            res_pc = tbl[i].pc;
            #1;
            chk($sformatf("tbl%0d_gnt", i), {31'd0, lkp_gnt}, {31'd0, tbl[i].gnt});
            chk($sformatf("tbl%0d_rdy", i), {31'd0, res_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("tbl%0d_vu", i), {31'd0, pht_vu}, {31'd0, tbl[i].vu});
            chk($sformatf("tbl%0d_pc", i), pht_pc, tbl[i].epc);
        end

        // Idle port: update issues the very next cycle with exact fields
        @(negedge clk);
        clear_inputs();
        res_valid = 1; res_pc = 32'h1000; res_ghr = 8'h5A;
        res_taken = 1; res_bias = 0;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("idle_vu", {31'd0, pht_vu}, 32'd1);
        chk("idle_pc", pht_pc, 32'h1000);
        chk("idle_ghr", {24'd0, pht_ghr}, 32'h5A);
        chk("idle_tk", {31'd0, pht_taken}, 32'd1);
        chk("idle_bias", {31'd0, pht_bias}, 32'd0);
        @(negedge clk);
        #1;
        chk("idle_drained", {31'd0, pht_vu}, 32'd0);

        // Reset mid-stream with 3 queued updates
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            lkp_req = 1; spec_valid = 1; spec_taken = 1;
            res_valid = 1; res_pc = 32'h300 + i; res_taken = 1;
        end
        @(negedge clk);
        clear_inputs();
        lkp_req = 1;
        #1;
        chk("pre_rst_spec", {24'd0, lkp_ghr}, 32'h07);
        rst_n = 0;
        #1;
        chk("mid_rst_ready", {31'd0, res_ready}, 32'd1);
        chk("mid_rst_vu", {31'd0, pht_vu}, 32'd0);
        chk("mid_rst_spec", {24'd0, lkp_ghr}, 32'd0);
        chk("mid_rst_commit", {24'd0, commit_ghr}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        lkp_req = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_upd", {31'd0, pht_vu}, 32'd0);
            chk("post_rst_ready", {31'd0, res_ready}, 32'd1);
        end

        // Mispredict recovery overrides a concurrent prediction
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clear_inputs();
            lkp_req = 1; spec_valid = 1; spec_taken = 1;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        chk("spec_ff", {24'd0, lkp_ghr}, 32'hFF);
        lkp_req = 1; spec_valid = 1; spec_taken = 0;
        res_valid = 1; res_ghr = 8'h12; res_taken = 1; res_mis = 1;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("mispred_ghr", {24'd0, lkp_ghr}, 32'h25);

        // Committed history pattern 1,0,1,1,0,0,1,0
        do_reset();
        begin
            logic [7:0] pat;
            pat = 8'b10110010;
            for (int i = 7; i >= 0; i--) begin
                @(negedge clk);
                clear_inputs();
                res_valid = 1; res_taken = pat[i]; res_pc = 32'h400;
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        chk("commit_b2", {24'd0, commit_ghr}, 32'hB2);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            lkp_req    = ($urandom_range(0, 3) != 0);
            lkp_pc     = $urandom;
            spec_valid = $urandom_range(0, 1);
            spec_taken = $urandom_range(0, 1);
            res_valid  = ($urandom_range(0, 2) == 0);
            res_pc     = $urandom;
            res_ghr    = 8'($urandom);
            res_taken  = $urandom_range(0, 1);
            res_bias   = $urandom_range(0, 1);
            res_mis    = ($urandom_range(0, 5) == 0);
            #1;
            model_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
